// File: rtl/hub75_rx_if.sv
// Pixel write stream leaving hub75_rx towards a capture framebuffer.
// master: the decoder driving writes; slave: the framebuffer consuming them.
interface hub75_rx_if #(
  parameter int COLS = 64,
  parameter int ROWS = 32
);
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  logic             wr_en;
  logic [ROW_W-1:0] wr_row;
  logic [2:0]       wr_plane;
  logic [COL_W-1:0] wr_col;
  logic [5:0]       wr_data;

  modport master (output wr_en, wr_row, wr_plane, wr_col, wr_data);
  modport slave  (input  wr_en, wr_row, wr_plane, wr_col, wr_data);
endinterface

// File: rtl/hub75_rx.sv
// Receive-side HUB75 decoder. Resynchronises the panel pins into sys_clk,
// tracks row / bit-plane / column from the shift, latch and row-token
// strobes, and emits one write per shifted pixel plus line/frame events.
// Optional feature macro: HUB75_RX_ONTIME_EN adds the blank-low on-time
// measurement (on_valid / on_cycles / on_plane); without it those outputs
// are tied to zero.
module hub75_rx #(
  parameter int COLS = 64,
  parameter int ROWS = 32,
  parameter int BITS = 6
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic                  hub_clk,
  input  logic                  hub_lat,
  input  logic                  hub_row_clk,
  input  logic                  hub_row_data,
  input  logic                  hub_blank,
  input  logic [5:0]            hub_rgb,
  input  logic                  err_clr,
  hub75_rx_if.master            wr,
  output logic                  line_done,
  output logic [$clog2(COLS):0] line_len,
  output logic                  frame_start,
  output logic                  locked,
  output logic                  err_col,
  output logic                  err_row,
  output logic                  on_valid,
  output logic [15:0]           on_cycles,
  output logic [2:0]            on_plane
);
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  localparam logic [COL_W:0]   COL_END    = (COL_W+1)'(COLS);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS-1);
  localparam logic [2:0]       PLANE_LAST = 3'(BITS-1);

  // Bit positions of each pin inside the synchroniser word.
  localparam int P_CLK    = 0;
  localparam int P_LAT    = 1;
  localparam int P_ROWCLK = 2;
  localparam int P_ROWDAT = 3;
  localparam int P_BLANK  = 4;
  localparam int P_RGB    = 5;

  typedef enum logic {ST_UNLOCKED, ST_LOCKED} state_t;

  logic [10:0] pins, s1, s2, s3;
  logic        rise_clk, rise_lat, rise_rowclk;
  logic        row_data;
  logic [5:0]  rgb;

  state_t           state;
  logic [ROW_W-1:0] row;
  logic [2:0]       plane;
  logic [COL_W:0]   col;

  logic           is_locked, pix_ok, col_ovf, row_wrap;
  logic [COL_W:0] col_pix;

  assign pins = {hub_rgb, hub_blank, hub_row_data, hub_row_clk, hub_lat, hub_clk};

  // Two-flop synchroniser, a history stage, and registered edge strobes.
  always_ff @(posedge sys_clk) begin
    // NOTE: the synchroniser is reset along with everything else, so all
    // pins read low after reset; a pin idling high then shows one rising
    // edge, which the UNLOCKED state ignores unless it is a genuine token.
    if (rst) begin
      s1          <= '0;
      s2          <= '0;
      s3          <= '0;
      rise_clk    <= 1'b0;
      rise_lat    <= 1'b0;
      rise_rowclk <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value, which is what makes this a shift chain.
      s1          <= pins;
      s2          <= s1;
      s3          <= s2;
      rise_clk    <= s2[P_CLK]    & ~s3[P_CLK];
      rise_lat    <= s2[P_LAT]    & ~s3[P_LAT];
      rise_rowclk <= s2[P_ROWCLK] & ~s3[P_ROWCLK];
    end
  end

  // Data is taken from the history stage, the same sample that produced the edge.
  assign row_data = s3[P_ROWDAT];
  assign rgb      = s3[P_RGB +: 6];

  assign is_locked = (state == ST_LOCKED);
  assign pix_ok    = is_locked && rise_clk && (col != COL_END);
  assign col_ovf   = is_locked && rise_clk && (col == COL_END);
  assign row_wrap  = is_locked && rise_rowclk && !row_data && (row == ROW_LAST);
  // Column count once this cycle's pixel (if any) has been accepted.
  assign col_pix   = col + (COL_W+1)'(pix_ok);

  // Lock tracking, position counters, write stream, line/frame events and sticky errors.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state       <= ST_UNLOCKED;
      row         <= '0;
      plane       <= '0;
      col         <= '0;
      locked      <= 1'b0;
      err_col     <= 1'b0;
      err_row     <= 1'b0;
      wr.wr_en    <= 1'b0;
      wr.wr_row   <= '0;
      wr.wr_plane <= '0;
      wr.wr_col   <= '0;
      wr.wr_data  <= '0;
      line_done   <= 1'b0;
      line_len    <= '0;
      frame_start <= 1'b0;
    end else begin
      wr.wr_en    <= 1'b0;
      line_done   <= 1'b0;
      frame_start <= 1'b0;

      // A fresh error in the same cycle as err_clr keeps the flag set.
      if (col_ovf)      err_col <= 1'b1;
      else if (err_clr) err_col <= 1'b0;
      if (row_wrap)     err_row <= 1'b1;
      else if (err_clr) err_row <= 1'b0;

      case (state)
        ST_UNLOCKED: begin
          if (rise_rowclk && row_data) begin
            state       <= ST_LOCKED;
            locked      <= 1'b1;
            row         <= '0;
            plane       <= '0;
            col         <= '0;
            frame_start <= 1'b1;
          end
        end

        ST_LOCKED: begin
          // The pixel uses the current position and belongs to any line latched now.
          if (pix_ok) begin
            wr.wr_en    <= 1'b1;
            wr.wr_row   <= row;
            wr.wr_plane <= plane;
            wr.wr_col   <= col[COL_W-1:0];
            wr.wr_data  <= rgb;
          end

          if (rise_lat) begin
            line_done <= 1'b1;
            line_len  <= col_pix;
          end

          // Row token beats latch for the position clear.
          if (rise_rowclk) begin
            plane <= '0;
            col   <= '0;
            if (row_data) begin
              row         <= '0;
              frame_start <= 1'b1;
            end else if (row == ROW_LAST) begin
              row <= '0;
            end else begin
              row <= row + ROW_W'(1);
            end
          end else if (rise_lat) begin
            col <= '0;
            if (plane != PLANE_LAST) plane <= plane + 3'd1;
          end else begin
            col <= col_pix;
          end
        end

        default: state <= ST_UNLOCKED;
      endcase
    end
  end

`ifdef HUB75_RX_ONTIME_EN
  logic        fall_blank, rise_blank;
  logic [15:0] on_cnt;

  // Count sys_clk cycles with blank low and report the total when blank rises.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      fall_blank <= 1'b0;
      rise_blank <= 1'b0;
      on_cnt     <= '0;
      on_valid   <= 1'b0;
      on_cycles  <= '0;
      on_plane   <= '0;
    end else begin
      fall_blank <= ~s2[P_BLANK] &  s3[P_BLANK];
      rise_blank <=  s2[P_BLANK] & ~s3[P_BLANK];
      on_valid   <= 1'b0;
      if (is_locked) begin
        // The falling-edge cycle is itself the first low cycle.
        if (fall_blank)
          on_cnt <= 16'd1;
        else if (!s3[P_BLANK] && on_cnt != 16'hFFFF)
          on_cnt <= on_cnt + 16'd1;
        if (rise_blank) begin
          on_valid  <= 1'b1;
          on_cycles <= on_cnt;
          on_plane  <= plane;
        end
      end
    end
  end
`else
  logic unused_blank;
  assign unused_blank = s3[P_BLANK];
  assign on_valid     = 1'b0;
  assign on_cycles    = '0;
  assign on_plane     = '0;
`endif

endmodule

// File: tb/tb_hub75_rx.sv
// Bench for hub75_rx: a directed step table walking the lock / plane / row /
// error / on-time scenarios, a latency and hold sequence, then randomized
// panel operations checked against a transaction-level model.
`timescale 1ns/1ps
module tb_hub75_rx;
  localparam int COLS = 64;
  localparam int ROWS = 32;
  localparam int BITS = 6;

  typedef enum int {OP_RST, OP_PIX, OP_LAT, OP_ROW, OP_LATROW, OP_CLR, OP_CLRPIX, OP_BLANK} op_e;

  typedef struct {
    op_e op;
    int  arg;
    int  rep;
    bit  locked;
    bit  err_col;
    bit  err_row;
    int  n_wr;
    int  len;
    int  on;
  } step_t;

  typedef struct packed {
    logic [4:0] row;
    logic [2:0] plane;
    logic [5:0] col;
    logic [5:0] data;
  } wr_t;

  typedef struct packed {
    logic [15:0] cycles;
    logic [2:0]  plane;
  } on_t;

  logic        sys_clk      = 1'b0;
  logic        rst          = 1'b1;
  logic        hub_clk      = 1'b0;
  logic        hub_lat      = 1'b0;
  logic        hub_row_clk  = 1'b0;
  logic        hub_row_data = 1'b0;
  logic        hub_blank    = 1'b1;
  logic [5:0]  hub_rgb      = '0;
  logic        err_clr      = 1'b0;
  logic        line_done;
  logic [6:0]  line_len;
  logic        frame_start;
  logic        locked;
  logic        err_col;
  logic        err_row;
  logic        on_valid;
  logic [15:0] on_cycles;
  logic [2:0]  on_plane;

  hub75_rx_if #(.COLS(COLS), .ROWS(ROWS)) wr_bus ();

  hub75_rx #(.COLS(COLS), .ROWS(ROWS), .BITS(BITS)) dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .hub_clk      (hub_clk),
    .hub_lat      (hub_lat),
    .hub_row_clk  (hub_row_clk),
    .hub_row_data (hub_row_data),
    .hub_blank    (hub_blank),
    .hub_rgb      (hub_rgb),
    .err_clr      (err_clr),
    .wr           (wr_bus),
    .line_done    (line_done),
    .line_len     (line_len),
    .frame_start  (frame_start),
    .locked       (locked),
    .err_col      (err_col),
    .err_row      (err_row),
    .on_valid     (on_valid),
    .on_cycles    (on_cycles),
    .on_plane     (on_plane)
  );

  always #5 sys_clk = ~sys_clk;

  int n_vec = 0;
  int n_bad = 0;

  // Observed and expected event streams.
  wr_t got_wr[$];
  wr_t exp_wr[$];
  int  got_line[$];
  int  exp_line[$];
  on_t got_on[$];
  on_t exp_on[$];
  int  got_fs = 0;
  int  exp_fs = 0;
  int  lat_seen = 0;

  // Reference model state.
  bit m_locked, m_err_col, m_err_row;
  int m_row, m_plane, m_col;

  // Capture DUT outputs on the falling edge, away from the active edge.
  always @(negedge sys_clk) begin
    if (!rst) begin
      if (wr_bus.wr_en) got_wr.push_back(wr_t'({wr_bus.wr_row, wr_bus.wr_plane, wr_bus.wr_col, wr_bus.wr_data}));
      if (line_done)    got_line.push_back(int'(line_len));
      if (frame_start)  got_fs++;
      if (on_valid)     got_on.push_back(on_t'({on_cycles, on_plane}));
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // ---------------- reference model ----------------
  task automatic m_reset();
    m_locked = 0; m_err_col = 0; m_err_row = 0;
    m_row = 0; m_plane = 0; m_col = 0;
  endtask

  task automatic m_pixel(input int rgb);
    wr_t w;
    if (!m_locked) return;
    if (m_col < COLS) begin
      w.row = 5'(m_row); w.plane = 3'(m_plane); w.col = 6'(m_col); w.data = 6'(rgb);
      exp_wr.push_back(w);
      m_col++;
    end else begin
      m_err_col = 1;
    end
  endtask

  task automatic m_latch();
    if (!m_locked) return;
    exp_line.push_back(m_col);
    m_col = 0;
    if (m_plane < BITS - 1) m_plane++;
  endtask

  task automatic m_row_clk(input bit d);
    if (d) begin
      m_locked = 1; m_row = 0; exp_fs++;
    end else if (m_locked) begin
      if (m_row == ROWS - 1) m_err_row = 1;
      m_row = (m_row + 1) % ROWS;
    end
    if (m_locked) begin m_plane = 0; m_col = 0; end
  endtask

  task automatic m_blank(input int n);
    on_t o;
    o.cycles = (n > 65535) ? 16'hFFFF : 16'(n);
    o.plane  = 3'(m_plane);
`ifdef HUB75_RX_ONTIME_EN
    if (m_locked) exp_on.push_back(o);
`endif
  endtask

  // ---------------- pin drivers ----------------
  task automatic do_reset();
    rst = 1'b1; cyc(3); rst = 1'b0; cyc(2);
  endtask

  task automatic do_pixel(input logic [5:0] rgb, input bit clr);
    hub_rgb = rgb; err_clr = clr; cyc(2);
    hub_clk = 1'b1;
    lat_seen = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge sys_clk);
      if (k == 3) hub_clk = 1'b0;
      if (k == 4) err_clr = 1'b0;
      if (wr_bus.wr_en && lat_seen == 0) lat_seen = k;
    end
    cyc(1);
  endtask

  task automatic do_latch();
    hub_lat = 1'b1; cyc(3); hub_lat = 1'b0; cyc(2);
  endtask

  task automatic do_row(input bit d);
    hub_row_data = d; cyc(2);
    hub_row_clk = 1'b1; cyc(3); hub_row_clk = 1'b0; cyc(2);
    hub_row_data = 1'b0; cyc(1);
  endtask

  task automatic do_latrow(input bit d);
    hub_row_data = d; cyc(2);
    hub_lat = 1'b1; hub_row_clk = 1'b1; cyc(3);
    hub_lat = 1'b0; hub_row_clk = 1'b0; cyc(2);
    hub_row_data = 1'b0; cyc(1);
  endtask

  task automatic do_blank(input int n);
    hub_blank = 1'b0; cyc(n); hub_blank = 1'b1; cyc(3);
  endtask

  task automatic do_clr();
    err_clr = 1'b1; cyc(1); err_clr = 1'b0; cyc(1);
  endtask

  task automatic flush();
    got_wr.delete(); exp_wr.delete();
    got_line.delete(); exp_line.delete();
    got_on.delete(); exp_on.delete();
    got_fs = 0; exp_fs = 0;
  endtask

  task automatic run_op(input op_e op, input int arg, input int rep);
    for (int i = 0; i < rep; i++) begin
      case (op)
        OP_RST:    begin do_reset(); m_reset(); flush(); end
        OP_PIX:    begin do_pixel(6'((arg + i) % 64), 1'b0); m_pixel((arg + i) % 64); end
        OP_LAT:    begin do_latch(); m_latch(); end
        OP_ROW:    begin do_row(arg != 0); m_row_clk(arg != 0); end
        OP_LATROW: begin do_latrow(arg != 0); m_latch(); m_row_clk(arg != 0); end
        OP_CLR:    begin do_clr(); m_err_col = 0; m_err_row = 0; end
        OP_CLRPIX: begin do_pixel(6'(arg % 64), 1'b1); m_err_col = 0; m_err_row = 0; m_pixel(arg % 64); end
        OP_BLANK:  begin do_blank(arg); m_blank(arg); end
        default: ;
      endcase
    end
  endtask

  // Compare everything observed since the last drain against the model.
  task automatic drain(input string tag);
    int n;
    check({tag, " wr_count"}, got_wr.size(), exp_wr.size());
    n = (got_wr.size() < exp_wr.size()) ? got_wr.size() : exp_wr.size();
    for (int i = 0; i < n; i++) begin
      check({tag, " wr_row"},   got_wr[i].row,   exp_wr[i].row);
      check({tag, " wr_plane"}, got_wr[i].plane, exp_wr[i].plane);
      check({tag, " wr_col"},   got_wr[i].col,   exp_wr[i].col);
      check({tag, " wr_data"},  got_wr[i].data,  exp_wr[i].data);
    end
    check({tag, " line_count"}, got_line.size(), exp_line.size());
    n = (got_line.size() < exp_line.size()) ? got_line.size() : exp_line.size();
    for (int i = 0; i < n; i++) check({tag, " line_len"}, got_line[i], exp_line[i]);
    check({tag, " frame_start"}, got_fs, exp_fs);
    check({tag, " on_count"}, got_on.size(), exp_on.size());
    n = (got_on.size() < exp_on.size()) ? got_on.size() : exp_on.size();
    for (int i = 0; i < n; i++) begin
      check({tag, " on_cycles"}, got_on[i].cycles, exp_on[i].cycles);
      check({tag, " on_plane"},  got_on[i].plane,  exp_on[i].plane);
    end
    check({tag, " locked"},  locked,  m_locked);
    check({tag, " err_col"}, err_col, m_err_col);
    check({tag, " err_row"}, err_row, m_err_row);
    flush();
  endtask

  function automatic step_t mk(op_e op, int arg, int rep, bit l, bit ec, bit er, int nw, int len, int on);
    step_t s;
    s.op = op; s.arg = arg; s.rep = rep;
    s.locked = l; s.err_col = ec; s.err_row = er;
    s.n_wr = nw; s.len = len; s.on = on;
    return s;
  endfunction

  initial begin
    step_t tbl[$];
    int    r;
    int    exp_col;

    m_reset();
    cyc(4); rst = 1'b0; cyc(2);
    check("reset locked",    locked,        0);
    check("reset err_col",   err_col,       0);
    check("reset err_row",   err_row,       0);
    check("reset wr_en",     wr_bus.wr_en,  0);
    check("reset line_len",  line_len,      0);
    check("reset on_cycles", on_cycles,     0);
    flush();

    //                 op         arg    rep lk ec er  n_wr len   on
    tbl.push_back(mk(OP_RST,       0,     1, 0, 0, 0,   0,  -1,   -1)); // 0
    tbl.push_back(mk(OP_PIX,       0,    10, 0, 0, 0,   0,  -1,   -1)); // 1 pre-lock pixels
    tbl.push_back(mk(OP_LAT,       0,     1, 0, 0, 0,   0,  -1,   -1)); // 2 pre-lock latch
    tbl.push_back(mk(OP_ROW,       1,     1, 1, 0, 0,   0,  -1,   -1)); // 3 token
    tbl.push_back(mk(OP_PIX,       0,    64, 1, 0, 0,  64,  -1,   -1)); // 4 first line
    tbl.push_back(mk(OP_LAT,       0,     1, 1, 0, 0,   0,  64,   -1)); // 5
    tbl.push_back(mk(OP_LAT,       0,     4, 1, 0, 0,   0,   0,   -1)); // 6 planes up to 5
    tbl.push_back(mk(OP_PIX,       7,     2, 1, 0, 0,   2,  -1,   -1)); // 7
    tbl.push_back(mk(OP_LAT,       0,     3, 1, 0, 0,   0,   0,   -1)); // 8 saturate
    tbl.push_back(mk(OP_PIX,      20,     2, 1, 0, 0,   2,  -1,   -1)); // 9
    tbl.push_back(mk(OP_ROW,       0,     1, 1, 0, 0,   0,  -1,   -1)); // 10 row 1
    tbl.push_back(mk(OP_PIX,      33,     3, 1, 0, 0,   3,  -1,   -1)); // 11
    tbl.push_back(mk(OP_LAT,       0,     1, 1, 0, 0,   0,   3,   -1)); // 12
    tbl.push_back(mk(OP_ROW,       1,     1, 1, 0, 0,   0,  -1,   -1)); // 13
    tbl.push_back(mk(OP_PIX,       0,    65, 1, 1, 0,  64,  -1,   -1)); // 14 overflow
    tbl.push_back(mk(OP_LAT,       0,     1, 1, 1, 0,   0,  64,   -1)); // 15
    tbl.push_back(mk(OP_ROW,       0,    32, 1, 1, 1,   0,  -1,   -1)); // 16 row wrap
    tbl.push_back(mk(OP_PIX,       9,     1, 1, 1, 1,   1,  -1,   -1)); // 17
    tbl.push_back(mk(OP_CLR,       0,     1, 1, 0, 0,   0,  -1,   -1)); // 18
    tbl.push_back(mk(OP_PIX,      40,     9, 1, 0, 0,   9,  -1,   -1)); // 19 col reaches 10
    tbl.push_back(mk(OP_LATROW,    0,     1, 1, 0, 0,   0,  10,   -1)); // 20 simultaneous
    tbl.push_back(mk(OP_PIX,      50,     1, 1, 0, 0,   1,  -1,   -1)); // 21 plane 0 col 0
    tbl.push_back(mk(OP_ROW,       0,    31, 1, 0, 1,   0,  -1,   -1)); // 22 wrap again
    tbl.push_back(mk(OP_PIX,       0,    64, 1, 0, 1,  64,  -1,   -1)); // 23
    tbl.push_back(mk(OP_CLRPIX,    5,     1, 1, 1, 0,   0,  -1,   -1)); // 24 new error wins
    tbl.push_back(mk(OP_LAT,       0,     3, 1, 1, 0,   0,   0,   -1)); // 25 plane 3
    tbl.push_back(mk(OP_BLANK,   256,     1, 1, 1, 0,   0,  -1,  256)); // 26
    tbl.push_back(mk(OP_BLANK, 70000,     1, 1, 1, 0,   0,  -1, 65535)); // 27
    tbl.push_back(mk(OP_PIX,      11,     5, 1, 1, 0,   5,  -1,   -1)); // 28
    tbl.push_back(mk(OP_RST,       0,     1, 0, 0, 0,   0,  -1,   -1)); // 29 mid-line reset
    tbl.push_back(mk(OP_PIX,      12,     5, 0, 0, 0,   0,  -1,   -1)); // 30
    tbl.push_back(mk(OP_LAT,       0,     1, 0, 0, 0,   0,  -1,   -1)); // 31
    tbl.push_back(mk(OP_BLANK,   100,     1, 0, 0, 0,   0,  -1,   -1)); // 32
    tbl.push_back(mk(OP_ROW,       1,     1, 1, 0, 0,   0,  -1,   -1)); // 33
    tbl.push_back(mk(OP_PIX,      60,     3, 1, 0, 0,   3,  -1,   -1)); // 34

    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].arg, tbl[i].rep);
      cyc(6);
      check($sformatf("step%0d n_wr", i), got_wr.size(), tbl[i].n_wr);
      if (tbl[i].len >= 0)
        check($sformatf("step%0d line_len", i), (got_line.size() > 0) ? got_line[$] : -1, tbl[i].len);
`ifdef HUB75_RX_ONTIME_EN
      if (tbl[i].on >= 0)
        check($sformatf("step%0d on_cycles", i), (got_on.size() > 0) ? int'(got_on[0].cycles) : -1, tbl[i].on);
`endif
      check($sformatf("step%0d locked", i),  locked,  tbl[i].locked);
      check($sformatf("step%0d err_col", i), err_col, tbl[i].err_col);
      check($sformatf("step%0d err_row", i), err_row, tbl[i].err_row);
      drain($sformatf("step%0d", i));
    end

    // Pin edge to wr_en takes four sys_clk; wr_* hold after the strobe.
    exp_col = m_col;
    do_pixel(6'h2A, 1'b0);
    m_pixel(42);
    check("wr latency", lat_seen, 4);
    cyc(6);
    check("wr hold col",  wr_bus.wr_col,  exp_col);
    check("wr hold data", wr_bus.wr_data, 42);
    drain("latency");

    // Randomized operations against the model.
    for (int t = 0; t < 120; t++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      run_op(OP_PIX, $urandom_range(0, 63), $urandom_range(1, 12));
      else if (r < 70) run_op(OP_LAT, 0, 1);
      else if (r < 80) run_op(OP_ROW, ($urandom_range(0, 3) == 0) ? 1 : 0, 1);
      else if (r < 85) run_op(OP_LATROW, ($urandom_range(0, 3) == 0) ? 1 : 0, 1);
      else if (r < 90) run_op(OP_CLR, 0, 1);
      else if (r < 95) run_op(OP_BLANK, $urandom_range(3, 400), 1);
      else             run_op(OP_CLRPIX, $urandom_range(0, 63), 1);
      cyc(6);
      drain($sformatf("rand%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
